// File: rtl/seg2bin_scanner.sv
// Scans a multiplexed, active-low 7-segment display bus and reassembles the
// four displayed hex digits into a 16-bit value with a valid/ready handshake.
module seg2bin_scanner #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  input  logic        out_ready,
  output logic [15:0] value,
  output logic        out_valid,
  output logic        seg_err,
  output logic        overflow
);

  localparam logic [3:0] COUNT_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] ACCEPT_AT = 4'(STABLE_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [6:0]  seg_prev_reg;
  logic [3:0]  sel_prev_reg;
  logic [3:0]  count_reg;
  logic [3:0]  count_next;
  logic [3:0]  mask_reg;
  logic [15:0] slots;

  logic [3:0]  sel_n;
  logic        qualified;
  logic        same;
  logic        accept;
  logic        dec_ok;
  logic [3:0]  dec_nibble;
  logic        is_blank;
  logic        is_bad;
  logic        frame_done;

  always_comb begin
    dec_ok     = 1'b1;
    dec_nibble = 4'h0;
    case (seg)
      7'h40: dec_nibble = 4'h0;
      7'h79: dec_nibble = 4'h1;
      7'h24: dec_nibble = 4'h2;
      7'h30: dec_nibble = 4'h3;
      7'h19: dec_nibble = 4'h4;
      7'h12: dec_nibble = 4'h5;
      7'h02: dec_nibble = 4'h6;
      7'h78: dec_nibble = 4'h7;
      7'h00: dec_nibble = 4'h8;
      7'h10: dec_nibble = 4'h9;
      7'h08: dec_nibble = 4'hA;
      7'h03: dec_nibble = 4'hB;
      7'h46: dec_nibble = 4'hC;
      7'h21: dec_nibble = 4'hD;
      7'h06: dec_nibble = 4'hE;
      7'h0E: dec_nibble = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  // A nonzero count implies the previous sample was qualified, so it doubles
  // as the "previous sample usable" flag.
  always_comb begin
    sel_n      = ~dig_sel;
    qualified  = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);
    same       = (count_reg != 4'd0) && (seg == seg_prev_reg) && (dig_sel == sel_prev_reg);
    accept     = qualified && same && (count_reg == ACCEPT_AT);
    is_blank   = (seg == SEG_BLANK);
    is_bad     = !dec_ok && !is_blank;
    frame_done = (mask_reg == 4'b1111);
    count_next = 4'd0;
    if (qualified) begin
      if (!same)
        count_next = 4'd1;
      else if (count_reg == COUNT_MAX)
        count_next = count_reg;
      else
        count_next = count_reg + 4'd1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    logic [3:0] slot_reg;
    always_ff @(posedge clk) begin
      if (reset)
        slot_reg <= 4'h0;
      else if (accept && dec_ok && !dig_sel[gi])
        slot_reg <= dec_nibble;
    end
    assign slots[4*gi +: 4] = slot_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_prev_reg <= 7'h0;
      sel_prev_reg <= 4'h0;
      count_reg    <= 4'd0;
      mask_reg     <= 4'd0;
      value        <= 16'h0;
      out_valid    <= 1'b0;
      seg_err      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      seg_prev_reg <= seg;
      sel_prev_reg <= dig_sel;
      count_reg    <= count_next;
      seg_err      <= accept && is_bad;

      if (frame_done)
        mask_reg <= 4'd0;
      else if (accept && is_bad)
        mask_reg <= 4'd0;
      else if (accept && dec_ok)
        mask_reg <= mask_reg | sel_n;

      // A completed frame either loads (consumer free or draining now) or is lost.
      if (frame_done && (!out_valid || out_ready)) begin
        value     <= slots;
        out_valid <= 1'b1;
      end else begin
        if (frame_done)
          overflow <= 1'b1;
        if (out_valid && out_ready)
          out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg2bin_scanner.sv
// Directed bench for seg2bin_scanner: drives inputs on the falling edge and
// checks outputs on the following falling edge against hand-computed values.
module tb_seg2bin_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        out_ready;
  logic [15:0] value;
  logic        out_valid;
  logic        seg_err;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  seg2bin_scanner #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .out_ready (out_ready),
    .value     (value),
    .out_valid (out_valid),
    .seg_err   (seg_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      dig_sel = sel;
      seg     = s;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    drive(4'b1111, 7'h7F, n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic frame(input logic [6:0] s3, input logic [6:0] s2,
                       input logic [6:0] s1, input logic [6:0] s0);
    drive(4'b1110, s0, 4);
    drive(4'b1101, s1, 4);
    drive(4'b1011, s2, 4);
    drive(4'b0111, s3, 4);
  endtask

  initial begin
    reset     = 1'b1;
    seg       = 7'h7F;
    dig_sel   = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();
    check("rst_value", value, 16'h0000);
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    check("rst_segerr", {15'd0, seg_err}, 16'd0);
    check("rst_ovf", {15'd0, overflow}, 16'd0);

    // Basic frame 0123, consumer ready
    frame(7'h40, 7'h79, 7'h24, 7'h30);
    check("f0123_pre_valid", {15'd0, out_valid}, 16'd0);
    idle(1);
    check("f0123_valid", {15'd0, out_valid}, 16'd1);
    check("f0123_value", value, 16'h0123);
    check("f0123_segerr", {15'd0, seg_err}, 16'd0);
    idle(1);
    check("f0123_drained", {15'd0, out_valid}, 16'd0);
    check("f0123_held", value, 16'h0123);

    // Overwrite, blank-ignore, and remaining decode entries: 89AB
    do_reset();
    drive(4'b1110, 7'h79, 4);
    drive(4'b1110, 7'h03, 4);
    drive(4'b1101, 7'h7F, 4);
    drive(4'b1101, 7'h08, 4);
    drive(4'b1011, 7'h10, 4);
    drive(4'b0111, 7'h00, 4);
    idle(1);
    check("f89ab_valid", {15'd0, out_valid}, 16'd1);
    check("f89ab_value", value, 16'h89AB);
    do_reset();
    frame(7'h46, 7'h21, 7'h06, 7'h0E);
    idle(1);
    check("fcdef_value", value, 16'hCDEF);

    // Digit held one cycle short never accepts
    do_reset();
    drive(4'b1110, 7'h30, 3);
    idle(2);
    drive(4'b1101, 7'h24, 4);
    drive(4'b1011, 7'h79, 4);
    drive(4'b0111, 7'h40, 4);
    idle(2);
    check("short_no_frame", {15'd0, out_valid}, 16'd0);

    // Undecodable pattern: single seg_err pulse over a long hold, mask cleared
    do_reset();
    drive(4'b1110, 7'h30, 4);
    drive(4'b1101, 7'h24, 4);
    for (int i = 1; i <= 8; i++) begin
      drive(4'b1011, 7'h7E, 1);
      check($sformatf("segerr_c%0d", i), {15'd0, seg_err}, (i == 4) ? 16'd1 : 16'd0);
    end
    idle(1);
    check("segerr_after", {15'd0, seg_err}, 16'd0);
    drive(4'b1011, 7'h79, 4);
    drive(4'b0111, 7'h40, 4);
    idle(2);
    check("segerr_mask_clr", {15'd0, out_valid}, 16'd0);

    // Overflow: second frame dropped while consumer stalls
    do_reset();
    out_ready = 1'b0;
    frame(7'h40, 7'h79, 7'h24, 7'h30);
    idle(1);
    check("ovf_f1_valid", {15'd0, out_valid}, 16'd1);
    check("ovf_f1_value", value, 16'h0123);
    check("ovf_f1_flag", {15'd0, overflow}, 16'd0);
    frame(7'h19, 7'h12, 7'h02, 7'h78);
    idle(1);
    check("ovf_f2_flag", {15'd0, overflow}, 16'd1);
    check("ovf_f2_value", value, 16'h0123);
    check("ovf_f2_valid", {15'd0, out_valid}, 16'd1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("ovf_drain_valid", {15'd0, out_valid}, 16'd0);
    check("ovf_sticky", {15'd0, overflow}, 16'd1);
    idle(2);
    check("ovf_sticky2", {15'd0, overflow}, 16'd1);

    // Reset discards a partial frame
    do_reset();
    check("ovf_rst_clear", {15'd0, overflow}, 16'd0);
    out_ready = 1'b1;
    drive(4'b1110, 7'h30, 4);
    drive(4'b1101, 7'h24, 4);
    drive(4'b1011, 7'h79, 4);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("partial_rst_value", value, 16'h0000);
    drive(4'b0111, 7'h40, 4);
    idle(2);
    check("partial_no_frame", {15'd0, out_valid}, 16'd0);

    // Two enables active: never qualified
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(4'b1100, 7'h00, 1);
      check($sformatf("multisel_c%0d", i), {15'd0, seg_err}, 16'd0);
    end
    check("multisel_valid", {15'd0, out_valid}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg2bin_scanner.md
SEG2BIN_SCANNER -- requirements
Module: seg2bin_scanner

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical samples required to accept a digit (legal range 2..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port seg, input, 7 bits: segment bus {g,f,e,d,c,b,a}, active low.
REQ-005 SHALL have port dig_sel, input, 4 bits: digit enables, active low, one-hot; dig_sel[0] is the least-significant digit.
REQ-006 SHALL have port out_ready, input, 1 bit: the consumer accepts value.
REQ-007 SHALL have port value, output, 16 bits: captured frame; digit i occupies value[4i+3:4i].
REQ-008 SHALL have port out_valid, output, 1 bit: value is valid and held.
REQ-009 SHALL have port seg_err, output, 1 bit: one-cycle pulse on acceptance of an undecodable pattern.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a completed frame is dropped.

Function
REQ-011 SHALL sample seg and dig_sel on every rising edge.
REQ-012 SHALL treat a sample as qualified only when exactly one dig_sel bit is 0; an unqualified sample restarts the stability run.
REQ-013 SHALL accept a digit on the edge where the same qualified (dig_sel, seg) pair has been sampled on STABLE_CYCLES consecutive edges, and exactly once per uninterrupted run.
REQ-014 SHALL restart the stability count whenever seg or dig_sel differs from the previous edge's sample.
REQ-015 SHALL decode accepted seg as follows: 0x40=0, 0x79=1, 0x24=2, 0x30=3, 0x19=4, 0x12=5, 0x02=6, 0x78=7, 0x00=8, 0x10=9, 0x08=A, 0x03=B, 0x46=C, 0x21=D, 0x06=E, 0x0E=F.
REQ-016 SHALL, on acceptance of a decodable pattern, write the nibble into the slot for the selected digit and set that digit's bit in the internal 4-bit frame mask.
REQ-017 SHALL, on acceptance of blank (0x7F), leave the slot and mask unchanged.
REQ-018 SHALL, on acceptance of any other pattern, pulse seg_err high for exactly one cycle (the cycle following the accept edge) and clear the frame mask.
REQ-019 SHALL let re-acceptance of an already-masked digit overwrite its slot.
REQ-020 SHALL treat mask==4'b1111 at an edge as frame complete; on that edge the mask clears and value/out_valid are updated, so the result is visible one cycle after the final accept.
REQ-021 SHALL, on frame complete with out_valid=0, or with out_valid=1 and out_ready=1, load value with the slots and set out_valid=1.
REQ-022 SHALL, on frame complete with out_valid=1 and out_ready=0, drop the frame, hold value, and set overflow=1.
REQ-023 SHALL keep value stable while out_valid=1; out_valid SHALL clear on the edge after out_valid&&out_ready unless a new frame loads on that same edge.
REQ-024 SHALL continue capturing digits while out_valid=1 (no backpressure on the input side).
REQ-025 SHALL clear overflow only on reset.

Reset
REQ-026 SHALL, when reset=1 at an edge, force value=0, out_valid=0, seg_err=0, overflow=0, frame mask=0, slots=0, and stability count=0.
REQ-027 SHALL give reset priority over every simultaneous event, including a pending accept or a frame completion.
REQ-028 SHALL require no partial frame to survive a reset; the stability run restarts on the first post-reset sample.

Verification
REQ-029 SHALL cover: dig_sel 1110/1101/1011/0111 with seg 0x30/0x24/0x79/0x40, each held 4 cycles, out_ready=1 -> one frame with value=0x0123, out_valid high.
REQ-030 SHALL cover: 0x30 on digit0 held 3 cycles then changed -> no accept; the frame never completes.
REQ-031 SHALL cover: seg=0x7E on digit2 held 4 cycles -> seg_err high for exactly 1 cycle, mask cleared, no out_valid.
REQ-032 SHALL cover: two complete frames (0x0123, then 0x4567) with out_ready=0 -> value stays 0x0123 and overflow=1; then out_ready=1 for 1 cycle -> out_valid falls and overflow stays 1.
REQ-033 SHALL cover: reset asserted after 3 digits are accepted, then only digit3 presented -> out_valid stays 0.
REQ-034 SHALL cover: dig_sel=1100 held 10 cycles with seg=0x00 -> no accept, no seg_err.
